rgb_mode_pwm: RTL and testbench



---
 rtl/rgb_mode_pwm.sv | 204 ++++++++++++++++++++
 tb/tb_rgb_mode_pwm.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rgb_mode_pwm.sv
// Button-driven RGB LED controller: short press steps colour mode, long press steps brightness.
// Optional triangle "breathing" brightness is built when RGB_BREATHE_EN is defined.
module rgb_mode_pwm #(
  parameter int PWM_PRESCALE     = 4,
  parameter int LONG_PRESS_COUNT = 50_000_000,
  parameter int BREATHE_STEP     = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_level,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic [2:0] mode,
  output logic [1:0] level
);

  localparam int HOLD_W  = $clog2(LONG_PRESS_COUNT);
  localparam int PRESC_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(LONG_PRESS_COUNT - 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PWM_PRESCALE - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  function automatic logic [7:0] level_duty(input logic [1:0] lv);
    logic [7:0] d;
    case (lv)
      2'd0:    d = 8'd64;
      2'd1:    d = 8'd128;
      2'd2:    d = 8'd192;
      default: d = 8'd255;
    endcase
    return d;
  endfunction

  logic               btn_prev_q;
  logic [1:0]         state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [2:0]         mode_q, mode_d;
  logic [1:0]         level_q, level_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [7:0]         pwm_cnt_q, pwm_cnt_d;
  logic [7:0]         duty_sh_q, duty_sh_d;
  logic [2:0]         en_sh_q, en_sh_d;
  logic [2:0]         led_q, led_d;
  logic               rise_s;
  logic               presc_wrap_s;
  logic               boundary_s;
  logic [7:0]         peak_s;
  logic [7:0]         duty_next_s;

  assign rise_s       = btn_level & ~btn_prev_q;
  assign presc_wrap_s = (presc_q == PRESC_LAST);
  assign boundary_s   = presc_wrap_s && (pwm_cnt_q == 8'hFF);
  assign peak_s       = level_duty(level_q);

  // One action per press: a release from HELD steps mode, reaching the hold limit steps level.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    mode_d     = mode_q;
    level_d    = level_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          state_d    = ST_HELD;
          hold_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (btn_level) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = ST_LONG;
            level_d = level_q + 2'd1;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end else begin
          state_d = ST_IDLE;
          mode_d  = mode_q + 3'd1;
        end
      end
      ST_LONG: begin
        if (!btn_level) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LONG;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef RGB_BREATHE_EN
  localparam int BR_W = (BREATHE_STEP > 1) ? $clog2(BREATHE_STEP) : 1;
  localparam logic [BR_W-1:0] BR_LAST = BR_W'(BREATHE_STEP - 1);

  logic [BR_W-1:0] br_cnt_q, br_cnt_d;
  logic [7:0]      breathe_q, breathe_d;
  logic            br_up_q, br_up_d;
  logic            br_tick_s;

  assign br_tick_s = (br_cnt_q == BR_LAST);

  // Triangle ramp; a lowered peak clamps the value at once and turns the ramp downward.
  always_comb begin
    br_cnt_d  = br_tick_s ? '0 : br_cnt_q + BR_W'(1);
    breathe_d = breathe_q;
    br_up_d   = br_up_q;
    if (breathe_q > peak_s) begin
      breathe_d = peak_s;
      br_up_d   = 1'b0;
    end else if (br_tick_s) begin
      if (br_up_q) begin
        if (breathe_q >= peak_s) begin
          br_up_d   = 1'b0;
          breathe_d = breathe_q - 8'd1;
        end else begin
          breathe_d = breathe_q + 8'd1;
        end
      end else begin
        if (breathe_q == 8'd0) begin
          br_up_d   = 1'b1;
          breathe_d = 8'd1;
        end else begin
          breathe_d = breathe_q - 8'd1;
        end
      end
    end else begin
      breathe_d = breathe_q;
    end
    duty_next_s = (breathe_q < peak_s) ? breathe_q : peak_s;
  end

  // Breathing ramp state.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q  <= '0;
      breathe_q <= 8'd0;
      br_up_q   <= 1'b1;
    end else begin
      br_cnt_q  <= br_cnt_d;
      breathe_q <= breathe_d;
      br_up_q   <= br_up_d;
    end
  end
`else
  logic [31:0] unused_breathe_step_s;
  assign unused_breathe_step_s = 32'(BREATHE_STEP);
  assign duty_next_s = peak_s;
`endif

  // PWM timebase; shadows only reload at the period boundary so a period is never cut short.
  always_comb begin
    presc_d   = presc_wrap_s ? '0 : presc_q + PRESC_W'(1);
    pwm_cnt_d = presc_wrap_s ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    if (boundary_s) begin
      duty_sh_d = duty_next_s;
      en_sh_d   = mode_q;
    end else begin
      duty_sh_d = duty_sh_q;
      en_sh_d   = en_sh_q;
    end
    led_d = en_sh_q & {3{pwm_cnt_q < duty_sh_q}};
  end

  // All state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      mode_q     <= 3'd0;
      level_q    <= 2'd1;
      presc_q    <= '0;
      pwm_cnt_q  <= 8'd0;
      duty_sh_q  <= 8'd0;
      en_sh_q    <= 3'd0;
      led_q      <= 3'd0;
    end else begin
      btn_prev_q <= btn_level;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      mode_q     <= mode_d;
      level_q    <= level_d;
      presc_q    <= presc_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_sh_q  <= duty_sh_d;
      en_sh_q    <= en_sh_d;
      led_q      <= led_d;
    end
  end

  assign led_r = led_q[0];
  assign led_g = led_q[1];
  assign led_b = led_q[2];
  assign mode  = mode_q;
  assign level = level_q;

endmodule

// File: tb/tb_rgb_mode_pwm.sv
// Directed self-checking bench for rgb_mode_pwm (PWM_PRESCALE=1, LONG_PRESS_COUNT=100).
module tb_rgb_mode_pwm;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_level;
  logic       led_r, led_g, led_b;
  logic [2:0] mode;
  logic [1:0] level;

  int checks = 0;
  int errors = 0;
  int cnt_r, cnt_g, cnt_b;

  rgb_mode_pwm #(
    .PWM_PRESCALE    (1),
    .LONG_PRESS_COUNT(100),
    .BREATHE_STEP    (200_000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_level(btn_level),
    .led_r    (led_r),
    .led_g    (led_g),
    .led_b    (led_b),
    .mode     (mode),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Let a full period with the new shadows start, then count highs over exactly one period.
  task automatic measure();
    repeat (300) tick();
    cnt_r = 0;
    cnt_g = 0;
    cnt_b = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      cnt_r += int'(led_r);
      cnt_g += int'(led_g);
      cnt_b += int'(led_b);
    end
  endtask

  task automatic short_press();
    btn_level = 1'b1;
    repeat (10) tick();
    btn_level = 1'b0;
    repeat (20) tick();
  endtask

  task automatic long_press(input int n);
    btn_level = 1'b1;
    repeat (n) tick();
    btn_level = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    rst = 1'b1;
    btn_level = 1'b0;

    // 1. reset
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_leds", {29'd0, led_b, led_g, led_r}, 32'd0);
      check("rst_mode", mode, 32'd0);
      check("rst_level", level, 32'd1);
    end
    rst = 1'b0;
    measure();
    check("off_r", cnt_r, 32'd0);
    check("off_g", cnt_g, 32'd0);
    check("off_b", cnt_b, 32'd0);
    check("post_rst_mode", mode, 32'd0);
    check("post_rst_level", level, 32'd1);

    // 2. single short press, exact mode update timing
    btn_level = 1'b1;
    repeat (10) tick();
    btn_level = 1'b0;
    check("mode_before_fall", mode, 32'd0);
    tick();
    check("mode_after_fall", mode, 32'd1);
    repeat (20) tick();
    measure();
    check("red128_r", cnt_r, 32'd128);
    check("red128_g", cnt_g, 32'd0);
    check("red128_b", cnt_b, 32'd0);

    // 3. step through modes 2..7, then wrap to 0 and back to 1
    for (int m = 2; m <= 7; m++) begin
      short_press();
      check("mode_step", mode, 32'(m));
    end
    check("level_unchanged", level, 32'd1);
    measure();
    check("white_r", cnt_r, 32'd128);
    check("white_g", cnt_g, 32'd128);
    check("white_b", cnt_b, 32'd128);
    short_press();
    check("mode_wrap", mode, 32'd0);
    short_press();
    check("mode_back1", mode, 32'd1);

    // 4. long press from level 1
    btn_level = 1'b1;
    repeat (95) tick();
    check("level_not_yet", level, 32'd1);
    repeat (10) tick();
    check("level_long", level, 32'd2);
    repeat (45) tick();
    btn_level = 1'b0;
    repeat (5) tick();
    check("mode_kept_long", mode, 32'd1);
    check("level_after_rel", level, 32'd2);
    measure();
    check("red192_r", cnt_r, 32'd192);
    check("red192_g", cnt_g, 32'd0);

    // 5. level 3, wrap to 0, then white at full
    long_press(150);
    check("level3", level, 32'd3);
    measure();
    check("red255_r", cnt_r, 32'd255);
    long_press(120);
    check("level_wrap", level, 32'd0);
    check("mode_still1", mode, 32'd1);
    measure();
    check("red64_r", cnt_r, 32'd64);
    for (int i = 0; i < 3; i++) long_press(120);
    check("level_back3", level, 32'd3);
    for (int i = 0; i < 6; i++) short_press();
    check("mode7", mode, 32'd7);
    measure();
    check("full_r", cnt_r, 32'd255);
    check("full_g", cnt_g, 32'd255);
    check("full_b", cnt_b, 32'd255);

    // 6. reset in the middle of a held press
    btn_level = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("midrst_leds", {29'd0, led_b, led_g, led_r}, 32'd0);
    rst = 1'b0;
    repeat (50) tick();
    btn_level = 1'b0;
    repeat (5) tick();
    check("midrst_mode", mode, 32'd0);
    check("midrst_level", level, 32'd1);
    short_press();
    check("midrst_next_press", mode, 32'd1);
    check("midrst_level_kept", level, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
